// File: rtl/immgen_pipe_if.sv
// Handshake bundle for immgen_pipe: fetch-side input word, decode-side immediate output, and flush.
// master drives the request side and out_ready; slave is the generator itself.
interface immgen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_fmt_err;

  modport master (
    output flush, in_valid, in_inst, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_fmt_err
  );

  modport slave (
    input  flush, in_valid, in_inst, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_fmt_err
  );
endinterface

// File: rtl/immgen_pipe.sv
// RV32I/RV64I immediate generator behind a 2-entry skid buffer; 1-cycle latency, in_ready registered.
// Optional CSR zimm (select 101) enabled by defining IMMGEN_ZIMM_EN.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  immgen_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } entry_t;

  state_e      state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic [31:0] imm32;
  entry_t      new_entry;
  logic        accept;
  logic        pop;
  logic        sgn;
  logic        unused_opcode;

  // Opcode bits carry no immediate payload.
  assign unused_opcode = ^bus.in_inst[6:0];
  assign sgn           = bus.in_inst[31];

  always_comb begin
    imm32         = '0;
    new_entry     = '0;
    new_entry.tag = bus.in_tag;
    case (bus.in_sel)
      3'b000: imm32 = {bus.in_inst[31:12], 12'b0};
      3'b001: imm32 = {{12{sgn}}, bus.in_inst[19:12], bus.in_inst[20], bus.in_inst[30:21], 1'b0};
      3'b010: imm32 = {{20{sgn}}, bus.in_inst[31:20]};
      3'b011: imm32 = {{20{sgn}}, bus.in_inst[7], bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};
      3'b100: imm32 = {{20{sgn}}, bus.in_inst[31:25], bus.in_inst[11:7]};
`ifdef IMMGEN_ZIMM_EN
      // Bit 31 is zero here, so the widening below zero-extends.
      3'b101: imm32 = {27'b0, bus.in_inst[19:15]};
`endif
      default: new_entry.err = 1'b1;
    endcase
    // U and J also follow the RV64 rule: every format widens from bit 31.
    new_entry.imm       = {XLEN{imm32[31]}};
    new_entry.imm[31:0] = imm32;
  end

  assign accept = bus.in_valid && in_ready_q;
  assign pop    = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = new_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        case ({accept, pop})
          2'b10: begin
            tail_d  = new_entry;
            state_d = FULL;
          end
          2'b01: begin
            head_d  = '0;
            state_d = EMPTY;
          end
          2'b11:   head_d = new_entry;
          default: ;
        endcase
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      state_d = EMPTY;
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_tag     = head_q.tag;
  assign bus.out_fmt_err = head_q.err;

endmodule

// File: tb/tb_immgen_pipe.sv
// Self-checking bench for immgen_pipe: directed vector table, backpressure/flush/reset sequences,
// then randomized traffic checked against an arithmetic immediate model and a FIFO scoreboard.
module tb_immgen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  immgen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  immgen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  vec_t tbl[10];
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Immediate value from the ISA field weights, as signed arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                           output logic err);
    longint v;
    longint s;
    logic [63:0] r;
    v   = 0;
    err = 1'b0;
    s   = longint'(inst[31]);
    case (sel)
      3'd0: v = longint'(inst[30:12]) * 4096 - s * 64'sd2147483648;
      3'd1: v = longint'(inst[30:21]) * 2 + longint'(inst[20]) * 2048
              + longint'(inst[19:12]) * 4096 - s * 1048576;
      3'd2: v = longint'(inst[30:20]) - s * 2048;
      3'd3: v = longint'(inst[11:8]) * 2 + longint'(inst[30:25]) * 32
              + longint'(inst[7]) * 2048 - s * 4096;
      3'd4: v = longint'(inst[11:7]) + longint'(inst[30:25]) * 32 - s * 2048;
`ifdef IMMGEN_ZIMM_EN
      3'd5: v = longint'(inst[19:15]);
`endif
      default: err = 1'b1;
    endcase
    r = 64'(v);
    if (XLEN == 32) r[63:32] = 32'h0;
    return r;
  endfunction

  function automatic logic [63:0] fit(input logic [63:0] x);
    logic [63:0] r;
    r = x;
    if (XLEN == 32) r[63:32] = 32'h0;
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst, input logic [2:0] sel,
                       input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_inst   = inst;
    bus.in_sel    = sel;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input exp_t e);
    chk({name, "_vld"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_imm"}, 64'(bus.out_imm), e.imm);
    chk({name, "_tag"}, 64'(bus.out_tag), 64'(e.tag));
    chk({name, "_err"}, 64'(bus.out_fmt_err), 64'(e.err));
  endtask

  function automatic exp_t mk(input logic [31:0] inst, input logic [2:0] sel,
                              input logic [TAG_W-1:0] tag);
    exp_t e;
    e.imm = ref_imm(inst, sel, e.err);
    e.tag = tag;
    return e;
  endfunction

  initial begin
    exp_t e;
    logic iv, ordy, fl, acc, pp;
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [TAG_W-1:0] tag;

    tbl[0] = '{32'hFFF00093, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[1] = '{32'h00500093, 3'd2, 64'h0000_0000_0000_0005, 1'b0};
    tbl[2] = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[3] = '{32'h12345037, 3'd0, 64'h0000_0000_1234_5000, 1'b0};
    tbl[4] = '{32'h0080006F, 3'd1, 64'h0000_0000_0000_0008, 1'b0};
    tbl[5] = '{32'hFE112E23, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[6] = '{32'hFFFFFFFF, 3'd6, 64'h0, 1'b1};
    tbl[7] = '{32'h80000037, 3'd0, 64'hFFFF_FFFF_8000_0000, 1'b0};
    tbl[8] = '{32'hFFFFFFFF, 3'd7, 64'h0, 1'b1};
`ifdef IMMGEN_ZIMM_EN
    tbl[9] = '{32'h3401D073, 3'd5, 64'h3, 1'b0};
`else
    tbl[9] = '{32'h3401D073, 3'd5, 64'h0, 1'b1};
`endif

    rst_n = 1'b0;
    drive(1'b0, 32'h0, 3'd0, '0, 1'b0, 1'b0);
    #12;
    chk("rst_vld", 64'(bus.out_valid), 64'd0);
    chk("rst_rdy", 64'(bus.in_ready), 64'd1);
    chk("rst_imm", 64'(bus.out_imm), 64'd0);
    chk("rst_tag", 64'(bus.out_tag), 64'd0);
    chk("rst_err", 64'(bus.out_fmt_err), 64'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors, one per cycle with the consumer always ready.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, tbl[i].inst, tbl[i].sel, TAG_W'(100 + i), 1'b1, 1'b0);
      step();
      e.imm = fit(tbl[i].exp);
      e.tag = TAG_W'(100 + i);
      e.err = tbl[i].err;
      chk_out($sformatf("vec%0d", i), e);
    end
    drive(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
    step();
    chk("drain_vld", 64'(bus.out_valid), 64'd0);

    // Backpressure: third input must wait until a slot frees.
    drive(1'b1, 32'h00100013, 3'd2, 1, 1'b0, 1'b0);
    step();
    chk("bp_rdy1", 64'(bus.in_ready), 64'd1);
    drive(1'b1, 32'h80000013, 3'd2, 2, 1'b0, 1'b0);
    step();
    chk("bp_rdy2", 64'(bus.in_ready), 64'd0);
    chk_out("bp_full", mk(32'h00100013, 3'd2, 1));
    drive(1'b1, 32'h7FF00013, 3'd2, 3, 1'b0, 1'b0);
    step();
    chk("bp_rdy3", 64'(bus.in_ready), 64'd0);
    chk_out("bp_hold", mk(32'h00100013, 3'd2, 1));
    drive(1'b1, 32'h7FF00013, 3'd2, 3, 1'b1, 1'b0);
    step();
    chk("bp_rdy4", 64'(bus.in_ready), 64'd1);
    chk_out("bp_pop1", mk(32'h80000013, 3'd2, 2));
    step();
    chk_out("bp_pop2", mk(32'h7FF00013, 3'd2, 3));
    drive(1'b0, 32'h0, 3'd0, '0, 1'b1, 1'b0);
    step();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // Flush from FULL with a concurrent input.
    drive(1'b1, 32'h00100013, 3'd2, 7, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00200013, 3'd2, 8, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00300013, 3'd2, 9, 1'b0, 1'b1);
    step();
    chk("fl_vld", 64'(bus.out_valid), 64'd0);
    chk("fl_rdy", 64'(bus.in_ready), 64'd1);
    // Flush from ONE: the accepted-looking input is discarded.
    drive(1'b1, 32'h00400013, 3'd2, 10, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h00500013, 3'd2, 11, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 3'd0, '0, 1'b0, 1'b0);
    chk("fl1_vld", 64'(bus.out_valid), 64'd0);
    step();
    chk("fl_lost", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 32'hFFF00093, 3'd2, 12, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'hFFF00093, 3'd2, 13, 1'b0, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.out_valid), 64'd0);
    chk("arst_rdy", 64'(bus.in_ready), 64'd1);
    chk("arst_imm", 64'(bus.out_imm), 64'd0);
    chk("arst_tag", 64'(bus.out_tag), 64'd0);
    chk("arst_err", 64'(bus.out_fmt_err), 64'd0);
    drive(1'b0, 32'h0, 3'd0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step();
    chk("arst_post", 64'(bus.out_valid), 64'd0);

    // Randomized traffic against the scoreboard.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      chk("rnd_rdy", 64'(bus.in_ready), 64'(q.size() != 2));
      chk("rnd_vld", 64'(bus.out_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("rnd_imm", 64'(bus.out_imm), q[0].imm);
        chk("rnd_tag", 64'(bus.out_tag), 64'(q[0].tag));
        chk("rnd_err", 64'(bus.out_fmt_err), 64'(q[0].err));
      end
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 39) == 0);
      inst = $urandom;
      sel  = 3'($urandom_range(0, 7));
      tag  = TAG_W'($urandom);
      drive(iv, inst, sel, tag, ordy, fl);
      acc = iv && (q.size() != 2);
      pp  = ordy && (q.size() != 0);
      step();
      if (fl) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(mk(inst, sel, tag));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
